// File: rtl/imem_access_arbiter.sv
// ---------------------------------------------------------------------------
// imem_access_arbiter
//
// Shares one instruction memory between two requesters:
//   port F : fetch unit, read-only
//   port L : program loader / debug port, read or write
// A granted access drives mem_E for ACCESS_CYCLES cycles with the address,
// data and write flag held stable. At the last edge of the window the read
// data is captured and a one-cycle acknowledge is raised for the granted port.
//
// Optional build macro: IMEM_WRITE_PROTECT_EN
//   When defined, a port-L write to an address below PROTECT_LIMIT keeps the
//   full access timing but never raises mem_E, and completes with l_err=1.
//   When undefined, every write proceeds and l_err is tied to 0.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   f_req/f_addr        fetch request and byte address
//   f_rdata/f_ack       fetched word and one-cycle completion pulse
//   l_req/l_we/l_addr/l_wdata  loader request, write flag, address, data
//   l_rdata/l_ack/l_err loader read data, completion pulse, rejected write
//   mem_E/mem_RW/mem_address/mem_dataIn  memory control, address, write data
//   mem_dataOut         memory read data
//   busy                high while an access is in ACCESS or DONE
//   owner               current or most recent grant (0 = F, 1 = L)
// ---------------------------------------------------------------------------
module imem_access_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter logic [63:0] PROTECT_LIMIT = 64'h400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic [31:0] f_rdata,
  output logic        f_ack,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [63:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_ack,
  output logic        l_err,
  output logic        mem_E,
  output logic        mem_RW,
  output logic [63:0] mem_address,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

`ifdef IMEM_WRITE_PROTECT_EN
  localparam bit PROTECT_ON = 1'b1;
`else
  localparam bit PROTECT_ON = 1'b0;
`endif

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic        blk_q, blk_d;      // current access is a rejected write
  logic [63:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] f_rdata_q, f_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;

  logic grant_f, grant_l, prot_hit;

  // Round robin: with both requests pending the port that did not win last
  // time is granted. owner resets to 1 so F wins the first contention.
  always_comb begin
    grant_l  = l_req && (!f_req || !owner_q);
    grant_f  = f_req && !grant_l;
    prot_hit = PROTECT_ON && l_we && (l_addr < PROTECT_LIMIT);
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: every register, including the read-data holding registers, has a
  // defined reset value so the outputs are all known right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      owner_q   <= 1'b1;
      we_q      <= 1'b0;
      blk_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      f_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update together.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      blk_q     <= blk_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      f_rdata_q <= f_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: hold-value defaults before the case keep this block latch-free.
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    we_d      = we_q;
    blk_d     = blk_q;
    addr_d    = addr_q;
    din_d     = din_q;
    f_rdata_d = f_rdata_q;
    l_rdata_d = l_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (grant_f || grant_l) begin
          state_d = ACCESS;
          owner_d = grant_l;
          cnt_d   = CNT_LOAD;
          if (grant_l) begin
            addr_d = l_addr;
            din_d  = l_wdata;
            we_d   = l_we;
            blk_d  = prot_hit;
          end else begin
            addr_d = f_addr;
            din_d  = '0;
            we_d   = 1'b0;
            blk_d  = 1'b0;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          // Writes leave the requester's read-data register untouched.
          if (!owner_q)   f_rdata_d = mem_dataOut;
          else if (!we_q) l_rdata_d = mem_dataOut;
          addr_d = '0;
          din_d  = '0;
          we_d   = 1'b0;
          // blk_q survives into DONE where it drives l_err.
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
        blk_d   = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  always_comb begin
    mem_E       = (state_q == ACCESS) && !blk_q;
    mem_RW      = we_q;
    mem_address = addr_q;
    mem_dataIn  = din_q;
    busy        = (state_q != IDLE);
    f_ack       = (state_q == DONE) && !owner_q;
    l_ack       = (state_q == DONE) &&  owner_q;
    f_rdata     = f_rdata_q;
    l_rdata     = l_rdata_q;
    owner       = owner_q;
  end

`ifdef IMEM_WRITE_PROTECT_EN
  assign l_err = (state_q == DONE) && owner_q && blk_q;
`else
  assign l_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_access_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for imem_access_arbiter.
// Main instance uses ACCESS_CYCLES=3, a second instance uses ACCESS_CYCLES=1.
// A simple behavioural memory answers the main instance; a shadow array of
// expected memory contents plus a round-robin owner variable form the
// reference model. Inputs are driven and outputs sampled on falling edges.
// ---------------------------------------------------------------------------
module tb_imem_access_arbiter;

  localparam int AC = 3;

`ifdef IMEM_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, l_req, l_we;
  logic [63:0] f_addr, l_addr;
  logic [31:0] l_wdata;
  logic [31:0] f_rdata, l_rdata;
  logic        f_ack, l_ack, l_err;
  logic        mem_E, mem_RW, busy, owner;
  logic [63:0] mem_address;
  logic [31:0] mem_dataIn, mem_dataOut;

  // fast instance (ACCESS_CYCLES = 1)
  logic        x_f_req, x_l_req, x_l_we;
  logic [63:0] x_f_addr, x_l_addr;
  logic [31:0] x_l_wdata;
  logic [31:0] x_f_rdata, x_l_rdata;
  logic        x_f_ack, x_l_ack, x_l_err;
  logic        x_mem_E, x_mem_RW, x_busy, x_owner;
  logic [63:0] x_mem_address;
  logic [31:0] x_mem_dataIn, x_mem_dataOut;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_access_arbiter #(.ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_rdata(l_rdata), .l_ack(l_ack), .l_err(l_err),
    .mem_E(mem_E), .mem_RW(mem_RW), .mem_address(mem_address),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut),
    .busy(busy), .owner(owner)
  );

  imem_access_arbiter #(.ACCESS_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst),
    .f_req(x_f_req), .f_addr(x_f_addr), .f_rdata(x_f_rdata), .f_ack(x_f_ack),
    .l_req(x_l_req), .l_we(x_l_we), .l_addr(x_l_addr), .l_wdata(x_l_wdata),
    .l_rdata(x_l_rdata), .l_ack(x_l_ack), .l_err(x_l_err),
    .mem_E(x_mem_E), .mem_RW(x_mem_RW), .mem_address(x_mem_address),
    .mem_dataIn(x_mem_dataIn), .mem_dataOut(x_mem_dataOut),
    .busy(x_busy), .owner(x_owner)
  );

  // Power-on memory contents: word at byte 0x4 holds 39.
  function automatic logic [31:0] init_word(input int unsigned idx);
    if (idx == 1) return 32'd39;
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Behavioural memory: 1024 words, indexed by byte address bits [11:2].
  logic [31:0] mem_arr [1024];
  bit          mem_wr  [1024];
  logic [9:0]  mem_idx;
  assign mem_idx = mem_address[11:2];
  always @(posedge clk) begin
    if (mem_E && mem_RW) begin
      mem_arr[mem_idx] <= mem_dataIn;
      mem_wr[mem_idx]  <= 1'b1;
    end
  end
  assign mem_dataOut   = mem_wr[mem_idx] ? mem_arr[mem_idx] : init_word(32'(mem_idx));
  assign x_mem_dataOut = init_word(32'(x_mem_address[11:2]));

  // Reference model state
  logic [31:0] ref_mem [1024];
  bit          last_owner;

  function automatic bit is_protected(input bit we, input logic [63:0] addr);
    return PROT && we && (addr < 64'h400);
  endfunction

  // -------------------------------------------------------------------------
  // One complete access on the main instance with full timing checks.
  // -------------------------------------------------------------------------
  task automatic do_access(input bit port_l, input bit we, input logic [63:0] addr,
                           input logic [31:0] wdata, input string tag);
    int n = 0, e_cycles = 0, busy_cycles = 0;
    int addr_bad = 0, rw_bad = 0, din_bad = 0, other_ack = 0;
    bit got = 0;
    bit prot;
    bit exp_rw;
    logic [31:0] exp_data, old_l;
    prot     = port_l && is_protected(we, addr);
    exp_rw   = port_l && we;
    exp_data = ref_mem[addr[11:2]];
    old_l    = l_rdata;

    @(negedge clk);
    if (port_l) begin
      l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end

    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (port_l ? f_ack : l_ack) other_ack++;
      if (port_l ? l_ack : f_ack) got = 1;
      else begin
        busy_cycles += int'(busy);
        e_cycles    += int'(mem_E);
        if (busy && mem_address !== addr) addr_bad++;
        if (busy && mem_RW !== exp_rw) rw_bad++;
        if (busy && exp_rw && mem_dataIn !== wdata) din_bad++;
      end
      // Inputs wander mid-access; the memory side must not follow.
      if (n == 1) begin
        f_addr = ~addr; l_addr = ~addr; l_wdata = ~wdata;
      end
    end

    total++;
    if (!got) begin
      bad++; $display("FAIL %s ack_timeout: no ack within %0d cycles", tag, n);
    end
    total++;
    if (n !== AC + 1) begin
      bad++; $display("FAIL %s latency: got %0d want %0d", tag, n, AC + 1);
    end
    total++;
    if (e_cycles !== (prot ? 0 : AC)) begin
      bad++; $display("FAIL %s mem_E_cycles: got %0d want %0d", tag, e_cycles, prot ? 0 : AC);
    end
    total++;
    if (busy_cycles !== AC || busy !== 1'b1) begin
      bad++; $display("FAIL %s busy: got %0d cycles ack_busy=%b want %0d cycles ack_busy=1", tag, busy_cycles, busy, AC);
    end
    total++;
    if (addr_bad != 0 || rw_bad != 0 || din_bad != 0) begin
      bad++; $display("FAIL %s mem_hold: addr_bad=%0d rw_bad=%0d din_bad=%0d want all 0", tag, addr_bad, rw_bad, din_bad);
    end
    total++;
    if (other_ack != 0) begin
      bad++; $display("FAIL %s other_ack: got %0d want 0", tag, other_ack);
    end
    total++;
    if (mem_E !== 1'b0 || mem_address !== 64'h0 || mem_RW !== 1'b0) begin
      bad++; $display("FAIL %s done_mem: got E=%b RW=%b addr=%h want 0 0 0", tag, mem_E, mem_RW, mem_address);
    end
    total++;
    if (l_err !== prot) begin
      bad++; $display("FAIL %s l_err: got %b want %b", tag, l_err, prot);
    end
    total++;
    if (owner !== port_l) begin
      bad++; $display("FAIL %s owner: got %b want %b", tag, owner, port_l);
    end
    total++;
    if (!port_l) begin
      if (f_rdata !== exp_data) begin
        bad++; $display("FAIL %s f_rdata: got %h want %h", tag, f_rdata, exp_data);
      end
    end else if (!we) begin
      if (l_rdata !== exp_data) begin
        bad++; $display("FAIL %s l_rdata: got %h want %h", tag, l_rdata, exp_data);
      end
    end else begin
      if (l_rdata !== old_l) begin
        bad++; $display("FAIL %s l_rdata_hold: got %h want %h", tag, l_rdata, old_l);
      end
    end

    if (port_l) l_req = 1'b0; else f_req = 1'b0;
    if (port_l && we && !prot) ref_mem[addr[11:2]] = wdata;
    last_owner = port_l;

    @(negedge clk);
    total++;
    if (f_ack !== 1'b0 || l_ack !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL %s ack_pulse: got f_ack=%b l_ack=%b busy=%b want 0 0 0", tag, f_ack, l_ack, busy);
    end
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({f_ack, l_ack, l_err, mem_E, mem_RW, busy} !== 6'b0) begin
      bad++; $display("FAIL reset ctrl: got %b want 000000", {f_ack, l_ack, l_err, mem_E, mem_RW, busy});
    end
    total++;
    if (mem_address !== 64'h0 || mem_dataIn !== 32'h0) begin
      bad++; $display("FAIL reset mem_bus: got addr=%h din=%h want 0 0", mem_address, mem_dataIn);
    end
    total++;
    if (f_rdata !== 32'h0 || l_rdata !== 32'h0) begin
      bad++; $display("FAIL reset rdata: got f=%h l=%h want 0 0", f_rdata, l_rdata);
    end
    total++;
    if (owner !== 1'b1 || x_owner !== 1'b1) begin
      bad++; $display("FAIL reset owner: got %b/%b want 1/1", owner, x_owner);
    end
    rst = 1'b0;
    last_owner = 1'b1;
  endtask

  task automatic test_single_read;
    int n = 0, e = 0, rw_hi = 0;
    bit got = 0;
    @(negedge clk);
    x_f_req = 1'b1; x_f_addr = 64'h4;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (x_f_ack) got = 1;
      else begin
        e += int'(x_mem_E);
        if (x_mem_E && x_mem_RW) rw_hi++;
      end
    end
    x_f_req = 1'b0;
    total++;
    if (n !== 2 || !got) begin
      bad++; $display("FAIL single_read latency: got %0d (ack=%b) want 2", n, got);
    end
    total++;
    if (e !== 1 || rw_hi !== 0) begin
      bad++; $display("FAIL single_read mem_E: got %0d cycles rw_hi=%0d want 1 and 0", e, rw_hi);
    end
    total++;
    if (x_f_rdata !== 32'd39) begin
      bad++; $display("FAIL single_read data: got %0d want 39", x_f_rdata);
    end
  endtask

  task automatic test_write_read;
    do_access(1'b1, 1'b1, 64'h800, 32'hDEADBEEF, "wr800");
    do_access(1'b0, 1'b0, 64'h800, 32'h0, "rd800");
    total++;
    if (f_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL write_read value: got %h want deadbeef", f_rdata);
    end
  endtask

  task automatic test_stretched;
    do_access(1'b0, 1'b0, 64'h4, 32'h0, "stretch_f");
    do_access(1'b1, 1'b0, 64'h4, 32'h0, "stretch_l");
  endtask

  task automatic test_contention;
    int n = 0, prev = 0, acks = 0;
    bit port, exp_port;
    logic [31:0] exp_data;
    rst = 1'b1;
    @(negedge clk);
    f_req = 1'b1; f_addr = 64'h40;
    l_req = 1'b1; l_we = 1'b0; l_addr = 64'h80;
    rst = 1'b0;
    last_owner = 1'b1;
    while (acks < 4 && n < 80) begin
      @(negedge clk);
      n++;
      if (f_ack && l_ack) begin
        total++; bad++; $display("FAIL contention both_ack: got both high at cycle %0d want one", n);
      end
      if (f_ack || l_ack) begin
        port     = l_ack;
        exp_port = !last_owner;
        exp_data = ref_mem[port ? 32 : 16];
        total++;
        if (port !== exp_port) begin
          bad++; $display("FAIL contention order[%0d]: got port %b want %b", acks, port, exp_port);
        end
        total++;
        if ((port ? l_rdata : f_rdata) !== exp_data) begin
          bad++; $display("FAIL contention data[%0d]: got %h want %h", acks, port ? l_rdata : f_rdata, exp_data);
        end
        total++;
        if ((n - prev) !== (acks == 0 ? AC + 1 : AC + 2)) begin
          bad++; $display("FAIL contention spacing[%0d]: got %0d want %0d", acks, n - prev, acks == 0 ? AC + 1 : AC + 2);
        end
        prev = n;
        last_owner = port;
        acks++;
      end
    end
    f_req = 1'b0; l_req = 1'b0;
    total++;
    if (acks !== 4) begin
      bad++; $display("FAIL contention count: got %0d acks want 4", acks);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    int n = 0;
    bit got = 0;
    @(negedge clk);
    f_req = 1'b1; f_addr = 64'h20;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_E !== 1'b1) begin
      bad++; $display("FAIL abort precond mem_E: got %b want 1", mem_E);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mem_E !== 1'b0 || busy !== 1'b0 || f_ack !== 1'b0 || f_rdata !== 32'h0) begin
      bad++; $display("FAIL abort outputs: got E=%b busy=%b ack=%b rdata=%h want 0 0 0 0", mem_E, busy, f_ack, f_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    last_owner = 1'b1;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (f_ack) got = 1;
    end
    f_req = 1'b0;
    last_owner = 1'b0;
    total++;
    if (!got || n !== AC + 1) begin
      bad++; $display("FAIL abort regrant: got ack=%b after %0d want ack after %0d", got, n, AC + 1);
    end
    total++;
    if (f_rdata !== ref_mem[8]) begin
      bad++; $display("FAIL abort data: got %h want %h", f_rdata, ref_mem[8]);
    end
    @(negedge clk);
  endtask

  task automatic test_protect;
    do_access(1'b1, 1'b1, 64'h10, 32'h1234_5678, "prot_wr");
    do_access(1'b0, 1'b0, 64'h10, 32'h0, "prot_rd");
  endtask

  task automatic test_random;
    int unsigned kind, idx, gap;
    logic [63:0] addr;
    logic [31:0] wdata;
    for (int i = 0; i < 30; i++) begin
      kind  = $urandom_range(0, 2);
      idx   = $urandom_range(0, 1023);
      gap   = $urandom_range(0, 2);
      addr  = {52'h0, idx[9:0], 2'b00};
      wdata = $urandom;
      for (int g = 0; g < int'(gap); g++) @(negedge clk);
      case (kind)
        0:       do_access(1'b0, 1'b0, addr, 32'h0, "rand_f");
        1:       do_access(1'b1, 1'b0, addr, wdata, "rand_lr");
        default: do_access(1'b1, 1'b1, addr, wdata, "rand_lw");
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    x_f_req = 1'b0; x_f_addr = '0;
    x_l_req = 1'b0; x_l_we = 1'b0; x_l_addr = '0; x_l_wdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(32'(i));

    test_reset();
    test_single_read();
    test_write_read();
    test_stretched();
    test_contention();
    test_reset_abort();
    test_protect();
    test_random();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
